// File: rtl/packet_uart_tx.sv
// packet_uart_tx: serialises a 256-bit packet as 32 back-to-back UART 8N1
// frames, byte 0 first, each byte LSB first. Accepting a packet is a
// valid/ready handshake: a packet is taken on a rising edge where
// i_pkt_valid=1 and o_pkt_ready=1. o_pkt_ready is high only while idle, and
// i_pkt_valid may be held high to chain packets. An abort request ends the
// packet after the byte in flight has been fully sent.
module packet_uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic         i_uart_clk,
    input  logic         i_rst_n,
    input  logic [255:0] i_packet,
    input  logic         i_pkt_valid,
    input  logic         i_abort,
    output logic         o_pkt_ready,
    output logic         o_tx_serial,
    output logic         o_tx_active,
    output logic [4:0]   o_byte_index,
    output logic         o_byte_done,
    output logic         o_pkt_done,
    output logic         o_pkt_aborted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Last cycle count of one bit period.
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]   state;
    logic [15:0]  clk_cnt;
    logic [2:0]   bit_cnt;
    // Buffer shifts right one bit per data bit, so the byte in flight is
    // always in the low bits and the next byte lands there after 8 shifts.
    logic [255:0] shift_buf;
    logic         abort_flag;
    logic         bit_end;
    logic         abort_pend;

    // Bit-period boundary and abort-pending view (includes a request on this very edge).
    always_comb begin
        bit_end    = (clk_cnt == BIT_LAST);
        abort_pend = abort_flag | i_abort;
    end

    assign o_pkt_ready = (state == ST_IDLE);
    assign o_tx_active = (state != ST_IDLE);

    // Frame sequencer: bit timing, serial line, byte index, status pulses.
    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            clk_cnt       <= 16'd0;
            bit_cnt       <= 3'd0;
            shift_buf     <= '0;
            abort_flag    <= 1'b0;
            o_tx_serial   <= 1'b1;
            o_byte_index  <= 5'd0;
            o_byte_done   <= 1'b0;
            o_pkt_done    <= 1'b0;
            o_pkt_aborted <= 1'b0;
        end else begin
            o_byte_done   <= 1'b0;
            o_pkt_done    <= 1'b0;
            o_pkt_aborted <= 1'b0;
            if ((state != ST_IDLE) && i_abort) begin
                abort_flag <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (i_pkt_valid) begin
                        shift_buf    <= i_packet;
                        o_byte_index <= 5'd0;
                        clk_cnt      <= 16'd0;
                        bit_cnt      <= 3'd0;
                        o_tx_serial  <= 1'b0;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        clk_cnt     <= 16'd0;
                        o_tx_serial <= shift_buf[0];
                        shift_buf   <= shift_buf >> 1;
                        state       <= ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt     <= 3'd0;
                            o_tx_serial <= 1'b1;
                            state       <= ST_STOP;
                        end else begin
                            bit_cnt     <= bit_cnt + 3'd1;
                            o_tx_serial <= shift_buf[0];
                            shift_buf   <= shift_buf >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        clk_cnt     <= 16'd0;
                        o_byte_done <= 1'b1;
                        if (o_byte_index == 5'd31) begin
                            // Completing the last byte wins over any pending abort.
                            o_pkt_done <= 1'b1;
                            abort_flag <= 1'b0;
                            state      <= ST_IDLE;
                        end else if (abort_pend) begin
                            o_pkt_aborted <= 1'b1;
                            abort_flag    <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            o_byte_index <= o_byte_index + 5'd1;
                            o_tx_serial  <= 1'b0;
                            state        <= ST_START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_uart_tx.sv
// tb_packet_uart_tx: directed bench for packet_uart_tx with CLKS_PER_BIT=4.
// The serial line is recorded every cycle and decoded by a mid-bit sampling
// receiver; decoded packets are checked against an expected-packet queue.
module tb_packet_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic         clk;
    logic         rst_n;
    logic [255:0] i_packet;
    logic         i_pkt_valid;
    logic         i_abort;
    logic         o_pkt_ready;
    logic         o_tx_serial;
    logic         o_tx_active;
    logic [4:0]   o_byte_index;
    logic         o_byte_done;
    logic         o_pkt_done;
    logic         o_pkt_aborted;

    packet_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_uart_clk    (clk),
        .i_rst_n       (rst_n),
        .i_packet      (i_packet),
        .i_pkt_valid   (i_pkt_valid),
        .i_abort       (i_abort),
        .o_pkt_ready   (o_pkt_ready),
        .o_tx_serial   (o_tx_serial),
        .o_tx_active   (o_tx_active),
        .o_byte_index  (o_byte_index),
        .o_byte_done   (o_byte_done),
        .o_pkt_done    (o_pkt_done),
        .o_pkt_aborted (o_pkt_aborted)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard state.
    logic [255:0] exp_q[$];
    logic         cap_tx[$];
    int           done_at[$];
    int           abrt_at[$];
    int           bdone_cnt;
    int           tail_bad;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_or_neg(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    // Offer one packet, then record the line every cycle (sample n follows
    // the nth edge after the accepting edge) until n_ends packet endings.
    // abort_n: sample after which i_abort is raised for one cycle.
    // chg_n: sample at which i_packet changes to chg_val (and to ~chg_val 1500 later).
    task automatic capture(input logic [255:0] pkt, input int abort_n, input int n_ends,
                           input int chg_n, input logic [255:0] chg_val);
        int n;
        int ends;
        cap_tx.delete();
        done_at.delete();
        abrt_at.delete();
        bdone_cnt = 0;
        tail_bad  = 0;
        ends      = 0;
        n         = 0;
        @(negedge clk);
        i_packet    = pkt;
        i_pkt_valid = 1'b1;
        @(posedge clk);
        while (ends < n_ends && n < 4000) begin
            @(negedge clk);
            cap_tx.push_back(o_tx_serial);
            if (o_byte_done) bdone_cnt++;
            if (o_pkt_done) begin
                done_at.push_back(n);
                ends++;
            end
            if (o_pkt_aborted) begin
                abrt_at.push_back(n);
                ends++;
            end
            i_abort = (n == abort_n);
            if (chg_n >= 0 && n == chg_n) i_packet = chg_val;
            if (chg_n >= 0 && n == chg_n + 1500) i_packet = ~chg_val;
            if (ends >= n_ends || n_ends == 1) i_pkt_valid = 1'b0;
            n++;
        end
        i_abort = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_tx_serial !== 1'b1 || o_pkt_ready !== 1'b1 || o_tx_active !== 1'b0 ||
                o_pkt_done !== 1'b0 || o_pkt_aborted !== 1'b0 || o_byte_done !== 1'b0)
                tail_bad++;
        end
    endtask

    // Mid-bit sampling receiver over the recorded line starting at sample base.
    task automatic decode(input int base, input int nbytes, output logic [255:0] pkt, output int ferr);
        pkt  = '0;
        ferr = 0;
        if (cap_tx.size() < base + nbytes * FRAME) begin
            ferr = 999;
        end else begin
            for (int k = 0; k < nbytes; k++) begin
                int s;
                s = base + k * FRAME;
                if (cap_tx[s + 2] !== 1'b0) ferr++;
                for (int b = 0; b < 8; b++) pkt[k * 8 + b] = cap_tx[s + (b + 1) * CPB + 2];
                if (cap_tx[s + 9 * CPB + 2] !== 1'b1) ferr++;
            end
        end
    endtask

    // Compare a decoded packet against the head of the expected queue.
    task automatic score(input string tag, input logic [255:0] got);
        logic [255:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
        check_eq(tag, got, exp);
    endtask

    logic [255:0] pk1, pk2, pka, pkb, got;
    logic [39:0]  obs40, exp40;
    logic [9:0]   a5_bits;
    int           ferr;

    initial begin
        rst_n       = 1'b0;
        i_packet    = '0;
        i_pkt_valid = 1'b0;
        i_abort     = 1'b0;
        for (int k = 0; k < 32; k++) begin
            pk1[k * 8 +: 8] = 8'(k);
            pk2[k * 8 +: 8] = 8'(k * 7 + 3);
            pka[k * 8 +: 8] = 8'(255 - k);
            pkb[k * 8 +: 8] = 8'(k * 17);
        end
        pk1[7:0] = 8'hA5;

        // Reset state.
        #23;
        check_eq("rst_tx",     256'(o_tx_serial),   256'(1));
        check_eq("rst_ready",  256'(o_pkt_ready),   256'(1));
        check_eq("rst_active", 256'(o_tx_active),   256'(0));
        check_eq("rst_index",  256'(o_byte_index),  256'(0));
        check_eq("rst_bdone",  256'(o_byte_done),   256'(0));
        check_eq("rst_pdone",  256'(o_pkt_done),    256'(0));
        check_eq("rst_abort",  256'(o_pkt_aborted), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Abort while idle has no effect on the next packet.
        i_abort = 1'b1;
        repeat (3) @(negedge clk);
        i_abort = 1'b0;

        // Single packet, byte0=0xA5, remaining bytes k.
        exp_q.push_back(pk1);
        capture(pk1, -1, 1, -1, '0);
        a5_bits = 10'b1101001010;  // bit i = i-th bit on the wire: 0,1,0,1,0,0,1,0,1,1
        for (int i = 0; i < 40; i++) begin
            exp40[i] = a5_bits[i / CPB];
            obs40[i] = (i < cap_tx.size()) ? cap_tx[i] : 1'bx;
        end
        check_eq("p1_first40", 256'(obs40), 256'(exp40));
        check_eq("p1_done_at", 256'(first_or_neg(done_at)), 256'(1280));
        check_eq("p1_n_abort", 256'(abrt_at.size()), 256'(0));
        check_eq("p1_bdone",   256'(bdone_cnt), 256'(32));
        decode(0, 32, got, ferr);
        score("p1_packet", got);
        check_eq("p1_framing", 256'(ferr), 256'(0));
        check_eq("p1_tail",    256'(tail_bad), 256'(0));
        check_eq("p1_idx_hold", 256'(o_byte_index), 256'(31));

        // Abort for one cycle in byte 5's data bits.
        exp_q.push_back({208'd0, pk2[47:0]});
        capture(pk2, 210, 1, -1, '0);
        check_eq("ab5_at",     256'(first_or_neg(abrt_at)), 256'(240));
        check_eq("ab5_n_done", 256'(done_at.size()), 256'(0));
        check_eq("ab5_bdone",  256'(bdone_cnt), 256'(6));
        decode(0, 6, got, ferr);
        score("ab5_bytes", got);
        check_eq("ab5_framing", 256'(ferr), 256'(0));
        check_eq("ab5_tail",   256'(tail_bad), 256'(0));
        check_eq("ab5_idx",    256'(o_byte_index), 256'(5));

        // Abort during byte 31: done wins, no abort pulse.
        capture(pk2, 1250, 1, -1, '0);
        check_eq("ab31_done_at", 256'(first_or_neg(done_at)), 256'(1280));
        check_eq("ab31_n_abort", 256'(abrt_at.size()), 256'(0));
        check_eq("ab31_bdone",   256'(bdone_cnt), 256'(32));
        check_eq("ab31_tail",    256'(tail_bad), 256'(0));

        // Valid held high: two packets, one idle cycle, i_packet changes ignored mid-packet.
        exp_q.push_back(pka);
        exp_q.push_back(pkb);
        capture(pka, -1, 2, 100, pkb);
        check_eq("b2b_n_done",  256'(done_at.size()), 256'(2));
        check_eq("b2b_done0",   256'(first_or_neg(done_at)), 256'(1280));
        check_eq("b2b_done1",   256'((done_at.size() > 1) ? done_at[1] : -1), 256'(2561));
        check_eq("b2b_gap",     256'((cap_tx.size() > 1281) ? {cap_tx[1279], cap_tx[1280], cap_tx[1281]} : 3'bxxx),
                 256'(3'b110));
        check_eq("b2b_bdone",   256'(bdone_cnt), 256'(64));
        decode(0, 32, got, ferr);
        score("b2b_pkt0", got);
        check_eq("b2b_framing0", 256'(ferr), 256'(0));
        decode(1281, 32, got, ferr);
        score("b2b_pkt1", got);
        check_eq("b2b_framing1", 256'(ferr), 256'(0));
        check_eq("b2b_tail",    256'(tail_bad), 256'(0));

        // Reset 100 cycles into a packet (byte 2, data bit 4 = 0 on the line).
        @(negedge clk);
        i_packet    = pk1;
        i_pkt_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_pkt_valid = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("mid_tx_before", 256'(o_tx_serial), 256'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx",    256'(o_tx_serial), 256'(1));
        check_eq("mid_rst_ready", 256'(o_pkt_ready), 256'(1));
        check_eq("mid_rst_idx",   256'(o_byte_index), 256'(0));
        @(negedge clk);
        check_eq("mid_rst_pulses", 256'({o_byte_done, o_pkt_done, o_pkt_aborted}), 256'(0));
        rst_n       = 1'b1;
        i_pkt_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_pkt_valid = 1'b0;
        check_eq("post_rst_tx",     256'(o_tx_serial), 256'(0));
        check_eq("post_rst_ready",  256'(o_pkt_ready), 256'(0));
        check_eq("post_rst_active", 256'(o_tx_active), 256'(1));
        check_eq("post_rst_idx",    256'(o_byte_index), 256'(0));

        check_eq("exp_q_drained", 256'(exp_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_uart_tx.md
PACKET_UART_TX -- requirements
Module: packet_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 87, i_uart_clk cycles per UART bit; legal range 2..65535.
REQ-002 i_uart_clk  input  1  UART-domain clock; all logic is on its rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_packet  input  256  packet to send; byte k = bits [8k+7:8k], k=0..31.
REQ-005 i_pkt_valid  input  1  packet-offer strobe.
REQ-006 i_abort  input  1  request to stop after the current byte.
REQ-007 o_pkt_ready  output  1  block idle and able to accept a packet.
REQ-008 o_tx_serial  output  1  UART 8N1 serial line; idle high.
REQ-009 o_tx_active  output  1  high while any frame bit is being driven.
REQ-010 o_byte_index  output  5  index of the byte currently in flight.
REQ-011 o_byte_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-012 o_pkt_done  output  1  one-cycle pulse after byte 31's stop bit.
REQ-013 o_pkt_aborted  output  1  one-cycle pulse when a packet ends early because of an abort.

Function
REQ-014 States: IDLE, START, DATA, STOP; o_pkt_ready = (state==IDLE), combinational.
REQ-015 Accept: on an edge with i_pkt_valid=1 in IDLE, latch i_packet into an internal 256-bit buffer, set byte index 0, go to START; i_packet is ignored outside IDLE.
REQ-016 Serial line: o_tx_serial is registered; it goes 0 on the accepting edge.
REQ-017 Bit timing: each bit (start, 8 data, stop) is held exactly CLKS_PER_BIT cycles; a frame is exactly 10*CLKS_PER_BIT cycles.
REQ-018 Bit order: data bits are sent LSB first; start bit = 0, stop bit = 1.
REQ-019 Byte order: bytes are sent in order 0..31 with no idle gap; the start bit of byte k+1 begins on the edge that ends the stop bit of byte k.
REQ-020 Stop bit end, index<31, no abort pending: pulse o_byte_done, increment the index, go to START.
REQ-021 Stop bit end, index==31: pulse o_byte_done and o_pkt_done together, go to IDLE; o_tx_serial stays 1.
REQ-022 Packet duration: accept edge to o_pkt_done pulse is 320*CLKS_PER_BIT cycles.
REQ-023 Back-to-back packets: a packet offered in the cycle after o_pkt_done is accepted; the line then shows no idle bit between packets beyond that cycle.
REQ-024 Abort: i_abort=1 on any cycle outside IDLE sets a sticky abort flag; the current byte completes in full.
REQ-025 Abort completion: at that byte's stop-bit end, pulse o_byte_done and o_pkt_aborted, clear the flag, go to IDLE, no o_pkt_done.
REQ-026 Abort during byte 31: o_pkt_done takes precedence and o_pkt_aborted is not pulsed.
REQ-027 i_abort in IDLE is ignored.
REQ-028 o_tx_active is 1 in START/DATA/STOP and 0 in IDLE.
REQ-029 o_byte_index holds the last byte index while in IDLE.
REQ-030 The bit-cycle counter and the bit counter reset to 0 at each bit/byte boundary; no counter wrap-around is observable at the outputs.

Reset
REQ-031 Reset values: state IDLE, o_tx_serial=1, o_pkt_ready=1, o_tx_active=0, o_byte_index=0, o_byte_done=0, o_pkt_done=0, o_pkt_aborted=0; buffer and counters are 0; abort flag is 0.
REQ-032 Reset mid-frame: the line goes to 1 immediately (asynchronously), and no done or abort pulse is generated.
REQ-033 After reset is released, the first accept is possible on the first rising edge.

Verification (CLKS_PER_BIT=4)
REQ-034 Single packet, byte0=0xA5 -> the first 40 cycles of o_tx_serial read 0,1,0,1,0,0,1,0,1,1 (each value held 4 cycles); o_pkt_done arrives 1280 cycles after accept; 32 o_byte_done pulses.
REQ-035 Packet with bytes k=k (0x00..0x1F) looped through the team's UART receiver and packet assembler -> the reassembled 256-bit packet equals the sent packet.
REQ-036 Abort asserted for 1 cycle during byte 5's DATA state -> byte 5 completes; o_pkt_aborted pulses at cycle 240 after accept; o_pkt_done is never pulsed; the line then stays 1.
REQ-037 Abort during byte 31 -> o_pkt_done pulses and o_pkt_aborted stays 0.
REQ-038 i_pkt_valid held high continuously -> 2 packets are sent with exactly 1 idle-high cycle between them; i_packet changes mid-packet do not alter the transmitted bytes.
REQ-039 Reset asserted at cycle 100 of a packet -> o_tx_serial=1 and o_pkt_ready=1 immediately; a new packet is accepted on the first edge after release.
